// File: rtl/axi_pkg.sv
// Shared AXI-lite constants, FSM state encodings and target select type
// for the MMIO demultiplexer.
package axi_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CLINT_AW = 16;
  localparam int unsigned RESP_W   = 2;

  localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wr_state_t;
  typedef enum logic [1:0] {TGT_CLINT, TGT_DEV, TGT_ERR} tgt_t;

endpackage

// File: rtl/mmio_addr_decode.sv
// Maps an upstream address onto a target window and its window-relative offset.
// Window ends are computed in 33 bits so a window touching 4 GiB cannot wrap.
module mmio_addr_decode
  import axi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [ADDR_W-1:0] CLINT_SIZE = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] DEV_BASE   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] DEV_SIZE   = 32'h0000_1000
) (
  input  logic [ADDR_W-1:0] addr_i,
  output tgt_t              tgt_o,
  output logic [ADDR_W-1:0] offset_o
);

  logic [ADDR_W:0] addr_ext;
  logic [ADDR_W:0] clint_end;
  logic [ADDR_W:0] dev_end;

  always_comb begin
    addr_ext  = {1'b0, addr_i};
    clint_end = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
    dev_end   = {1'b0, DEV_BASE} + {1'b0, DEV_SIZE};
    tgt_o     = TGT_ERR;
    offset_o  = '0;
    if (addr_ext >= {1'b0, CLINT_BASE} && addr_ext < clint_end) begin
      tgt_o    = TGT_CLINT;
      offset_o = addr_i - CLINT_BASE;
    end else if (addr_ext >= {1'b0, DEV_BASE} && addr_ext < dev_end) begin
      tgt_o    = TGT_DEV;
      offset_o = addr_i - DEV_BASE;
    end
  end

endmodule

// File: rtl/mmio_axi_demux.sv
// 1-to-2 AXI-lite MMIO demux: CLINT (16-bit offsets) and device window,
// with local DECERR for unmapped addresses. Independent read and write paths.
module mmio_axi_demux
  import axi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [ADDR_W-1:0] CLINT_SIZE = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] DEV_BASE   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] DEV_SIZE   = 32'h0000_1000
) (
  input  logic                clk,
  input  logic                rst,
  // upstream
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [RESP_W-1:0]   s_axi_bresp,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [RESP_W-1:0]   s_axi_rresp,
  // target 0: CLINT
  output logic [CLINT_AW-1:0] m0_axi_awaddr,
  output logic                m0_axi_awvalid,
  input  logic                m0_axi_awready,
  output logic [DATA_W-1:0]   m0_axi_wdata,
  output logic                m0_axi_wvalid,
  input  logic                m0_axi_wready,
  input  logic                m0_axi_bvalid,
  output logic                m0_axi_bready,
  input  logic [RESP_W-1:0]   m0_axi_bresp,
  output logic [CLINT_AW-1:0] m0_axi_araddr,
  output logic                m0_axi_arvalid,
  input  logic                m0_axi_arready,
  input  logic                m0_axi_rvalid,
  output logic                m0_axi_rready,
  input  logic [DATA_W-1:0]   m0_axi_rdata,
  input  logic [RESP_W-1:0]   m0_axi_rresp,
  // target 1: device window
  output logic [ADDR_W-1:0]   m1_axi_awaddr,
  output logic                m1_axi_awvalid,
  input  logic                m1_axi_awready,
  output logic [DATA_W-1:0]   m1_axi_wdata,
  output logic                m1_axi_wvalid,
  input  logic                m1_axi_wready,
  input  logic                m1_axi_bvalid,
  output logic                m1_axi_bready,
  input  logic [RESP_W-1:0]   m1_axi_bresp,
  output logic [ADDR_W-1:0]   m1_axi_araddr,
  output logic                m1_axi_arvalid,
  input  logic                m1_axi_arready,
  input  logic                m1_axi_rvalid,
  output logic                m1_axi_rready,
  input  logic [DATA_W-1:0]   m1_axi_rdata,
  input  logic [RESP_W-1:0]   m1_axi_rresp
);

  tgt_t              ar_tgt;
  tgt_t              aw_tgt;
  logic [ADDR_W-1:0] ar_off;
  logic [ADDR_W-1:0] aw_off;

  mmio_addr_decode #(
    .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE),
    .DEV_BASE(DEV_BASE), .DEV_SIZE(DEV_SIZE)
  ) u_ar_decode (
    .addr_i(s_axi_araddr), .tgt_o(ar_tgt), .offset_o(ar_off)
  );

  mmio_addr_decode #(
    .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE),
    .DEV_BASE(DEV_BASE), .DEV_SIZE(DEV_SIZE)
  ) u_aw_decode (
    .addr_i(s_axi_awaddr), .tgt_o(aw_tgt), .offset_o(aw_off)
  );

  // ---------------- read path ----------------
  rd_state_t         rd_state_q;
  tgt_t              ar_tgt_q;
  logic [ADDR_W-1:0] ar_off_q;
  logic              arready_q;
  logic              arvalid_q;

  logic              rd_t_arready;
  logic              rd_t_rvalid;
  logic [DATA_W-1:0] rd_t_rdata;
  logic [RESP_W-1:0] rd_t_rresp;
  logic              rd_resp;

  always_comb begin
    rd_t_arready = (ar_tgt_q == TGT_DEV) ? m1_axi_arready : m0_axi_arready;
    rd_t_rvalid  = (ar_tgt_q == TGT_DEV) ? m1_axi_rvalid  : m0_axi_rvalid;
    rd_t_rdata   = (ar_tgt_q == TGT_DEV) ? m1_axi_rdata   : m0_axi_rdata;
    rd_t_rresp   = (ar_tgt_q == TGT_DEV) ? m1_axi_rresp   : m0_axi_rresp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      ar_tgt_q   <= TGT_CLINT;
      ar_off_q   <= '0;
      arready_q  <= 1'b1;
      arvalid_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (s_axi_arvalid && arready_q) begin
          arready_q <= 1'b0;
          ar_tgt_q  <= ar_tgt;
          ar_off_q  <= ar_off;
          if (ar_tgt == TGT_ERR) begin
            rd_state_q <= R_ERR;
          end else begin
            rd_state_q <= R_ADDR;
            arvalid_q  <= 1'b1;
          end
        end
        R_ADDR: if (rd_t_arready) begin
          arvalid_q  <= 1'b0;
          rd_state_q <= R_RESP;
        end
        R_RESP: if (rd_t_rvalid && s_axi_rready) begin
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        R_ERR: if (s_axi_rready) begin
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // response phase is a zero-latency pass-through of the selected target
  always_comb begin
    rd_resp        = (rd_state_q == R_RESP);
    s_axi_arready  = arready_q;
    m0_axi_araddr  = ar_off_q[CLINT_AW-1:0];
    m1_axi_araddr  = ar_off_q;
    m0_axi_arvalid = arvalid_q && (ar_tgt_q == TGT_CLINT);
    m1_axi_arvalid = arvalid_q && (ar_tgt_q == TGT_DEV);
    m0_axi_rready  = rd_resp && (ar_tgt_q == TGT_CLINT) && s_axi_rready;
    m1_axi_rready  = rd_resp && (ar_tgt_q == TGT_DEV) && s_axi_rready;
    s_axi_rvalid   = (rd_resp && rd_t_rvalid) || (rd_state_q == R_ERR);
    s_axi_rdata    = rd_resp ? rd_t_rdata : '0;
    s_axi_rresp    = AXI_RESP_OKAY;
    if (rd_resp) begin
      s_axi_rresp = rd_t_rresp;
    end else if (rd_state_q == R_ERR) begin
      s_axi_rresp = AXI_RESP_DECERR;
    end
  end

  // ---------------- write path ----------------
  wr_state_t         wr_state_q;
  tgt_t              aw_tgt_q;
  logic [ADDR_W-1:0] aw_off_q;
  logic [DATA_W-1:0] wdata_q;
  logic              awready_q;
  logic              wready_q;
  logic              awvalid_q;
  logic              wvalid_q;

  logic              wr_t_awready;
  logic              wr_t_wready;
  logic              wr_t_bvalid;
  logic [RESP_W-1:0] wr_t_bresp;
  logic              aw_hs;
  logic              w_hs;
  logic              aw_have;
  logic              w_have;
  tgt_t              wr_tgt_now;
  logic              aw_done;
  logic              w_done;

  always_comb begin
    wr_t_awready = (aw_tgt_q == TGT_DEV) ? m1_axi_awready : m0_axi_awready;
    wr_t_wready  = (aw_tgt_q == TGT_DEV) ? m1_axi_wready  : m0_axi_wready;
    wr_t_bvalid  = (aw_tgt_q == TGT_DEV) ? m1_axi_bvalid  : m0_axi_bvalid;
    wr_t_bresp   = (aw_tgt_q == TGT_DEV) ? m1_axi_bresp   : m0_axi_bresp;
    aw_hs        = s_axi_awvalid && awready_q;
    w_hs         = s_axi_wvalid && wready_q;
    aw_have      = aw_hs || !awready_q;
    w_have       = w_hs || !wready_q;
    wr_tgt_now   = aw_hs ? aw_tgt : aw_tgt_q;
    aw_done      = !awvalid_q || wr_t_awready;
    w_done       = !wvalid_q || wr_t_wready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_tgt_q   <= TGT_CLINT;
      aw_off_q   <= '0;
      wdata_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        // AW and W are captured independently; forward once both are held
        W_IDLE: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            aw_tgt_q  <= aw_tgt;
            aw_off_q  <= aw_off;
          end
          if (w_hs) begin
            wready_q <= 1'b0;
            wdata_q  <= s_axi_wdata;
          end
          if (aw_have && w_have) begin
            if (wr_tgt_now == TGT_ERR) begin
              wr_state_q <= W_ERR;
            end else begin
              wr_state_q <= W_FWD;
              awvalid_q  <= 1'b1;
              wvalid_q   <= 1'b1;
            end
          end
        end
        W_FWD: begin
          if (awvalid_q && wr_t_awready) awvalid_q <= 1'b0;
          if (wvalid_q && wr_t_wready) wvalid_q <= 1'b0;
          if (aw_done && w_done) wr_state_q <= W_RESP;
        end
        W_RESP: if (wr_t_bvalid && s_axi_bready) begin
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        W_ERR: if (s_axi_bready) begin
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axi_awready  = awready_q;
    s_axi_wready   = wready_q;
    m0_axi_awaddr  = aw_off_q[CLINT_AW-1:0];
    m1_axi_awaddr  = aw_off_q;
    m0_axi_wdata   = wdata_q;
    m1_axi_wdata   = wdata_q;
    m0_axi_awvalid = awvalid_q && (aw_tgt_q == TGT_CLINT);
    m1_axi_awvalid = awvalid_q && (aw_tgt_q == TGT_DEV);
    m0_axi_wvalid  = wvalid_q && (aw_tgt_q == TGT_CLINT);
    m1_axi_wvalid  = wvalid_q && (aw_tgt_q == TGT_DEV);
    m0_axi_bready  = (wr_state_q == W_RESP) && (aw_tgt_q == TGT_CLINT) && s_axi_bready;
    m1_axi_bready  = (wr_state_q == W_RESP) && (aw_tgt_q == TGT_DEV) && s_axi_bready;
    s_axi_bvalid   = ((wr_state_q == W_RESP) && wr_t_bvalid) || (wr_state_q == W_ERR);
    s_axi_bresp    = AXI_RESP_OKAY;
    if (wr_state_q == W_RESP) begin
      s_axi_bresp = wr_t_bresp;
    end else if (wr_state_q == W_ERR) begin
      s_axi_bresp = AXI_RESP_DECERR;
    end
  end

endmodule

// File: tb/tb_mmio_axi_demux.sv
// Bench for mmio_axi_demux: two simple target slaves, a transaction-level
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_mmio_axi_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [63:0] s_axi_wdata;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [63:0] s_axi_rdata;
  logic [15:0] m0_axi_awaddr, m0_axi_araddr;
  logic [31:0] m1_axi_awaddr, m1_axi_araddr;
  logic [63:0] m0_axi_wdata, m1_axi_wdata, m0_axi_rdata, m1_axi_rdata;
  logic        m0_axi_awvalid, m0_axi_wvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_rready;
  logic        m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_rready;
  logic        m0_axi_awready, m0_axi_wready, m0_axi_bvalid, m0_axi_arready, m0_axi_rvalid;
  logic        m1_axi_awready, m1_axi_wready, m1_axi_bvalid, m1_axi_arready, m1_axi_rvalid;
  logic [1:0]  m0_axi_bresp, m0_axi_rresp, m1_axi_bresp, m1_axi_rresp;

  always #5 clk = ~clk;

  mmio_axi_demux dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
    .m0_axi_wdata(m0_axi_wdata), .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready),
    .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready), .m0_axi_bresp(m0_axi_bresp),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
    .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready), .m0_axi_rdata(m0_axi_rdata),
    .m0_axi_rresp(m0_axi_rresp),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready),
    .m1_axi_wdata(m1_axi_wdata), .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready),
    .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready), .m1_axi_bresp(m1_axi_bresp),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
    .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready), .m1_axi_rdata(m1_axi_rdata),
    .m1_axi_rresp(m1_axi_rresp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL timeout %s: got no handshake want handshake @%0t", nm, $time);
  endtask

  // ---------------- target slave models ----------------
  logic        sl_arready [2];
  logic        sl_rvalid  [2];
  logic [63:0] sl_rdata   [2];
  logic        sl_bvalid  [2];
  logic [63:0] rd_ret     [2];
  logic        aw_got [2], w_got [2];
  logic        hs_ar [2], hs_r [2], hs_aw [2], hs_w [2], hs_b [2];
  logic [31:0] cap_ar [2], cap_aw [2];
  logic [63:0] cap_w [2];
  int          ar_cnt [2], aw_cnt [2], w_cnt [2];
  logic [31:0] last_ar [2], last_aw [2];
  logic [63:0] last_w [2];
  logic        rst_s;

  assign m0_axi_arready = sl_arready[0];
  assign m1_axi_arready = sl_arready[1];
  assign m0_axi_rvalid  = sl_rvalid[0];
  assign m1_axi_rvalid  = sl_rvalid[1];
  assign m0_axi_rdata   = sl_rdata[0];
  assign m1_axi_rdata   = sl_rdata[1];
  assign m0_axi_rresp   = 2'b00;
  assign m1_axi_rresp   = 2'b01;
  assign m0_axi_awready = 1'b1;
  assign m1_axi_awready = 1'b1;
  assign m0_axi_wready  = 1'b1;
  assign m1_axi_wready  = 1'b1;
  assign m0_axi_bvalid  = sl_bvalid[0];
  assign m1_axi_bvalid  = sl_bvalid[1];
  assign m0_axi_bresp   = 2'b00;
  assign m1_axi_bresp   = 2'b00;

  always @(negedge clk) begin
    rst_s     = rst;
    hs_ar[0]  = m0_axi_arvalid && m0_axi_arready;
    hs_ar[1]  = m1_axi_arvalid && m1_axi_arready;
    hs_r[0]   = m0_axi_rvalid && m0_axi_rready;
    hs_r[1]   = m1_axi_rvalid && m1_axi_rready;
    hs_aw[0]  = m0_axi_awvalid && m0_axi_awready;
    hs_aw[1]  = m1_axi_awvalid && m1_axi_awready;
    hs_w[0]   = m0_axi_wvalid && m0_axi_wready;
    hs_w[1]   = m1_axi_wvalid && m1_axi_wready;
    hs_b[0]   = m0_axi_bvalid && m0_axi_bready;
    hs_b[1]   = m1_axi_bvalid && m1_axi_bready;
    cap_ar[0] = 32'(m0_axi_araddr);
    cap_ar[1] = m1_axi_araddr;
    cap_aw[0] = 32'(m0_axi_awaddr);
    cap_aw[1] = m1_axi_awaddr;
    cap_w[0]  = m0_axi_wdata;
    cap_w[1]  = m1_axi_wdata;
  end

  // Each slave answers a read one cycle after AR and a write one cycle after AW+W.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst_s) begin
        sl_rvalid[i] = 1'b0;
        sl_bvalid[i] = 1'b0;
        aw_got[i]    = 1'b0;
        w_got[i]     = 1'b0;
      end else begin
        if (hs_r[i]) sl_rvalid[i] = 1'b0;
        if (hs_ar[i]) begin
          ar_cnt[i]++;
          last_ar[i]   = cap_ar[i];
          sl_rvalid[i] = 1'b1;
          sl_rdata[i]  = rd_ret[i];
        end
        if (hs_b[i]) sl_bvalid[i] = 1'b0;
        if (hs_aw[i]) begin
          aw_cnt[i]++;
          last_aw[i] = cap_aw[i];
          aw_got[i]  = 1'b1;
        end
        if (hs_w[i]) begin
          w_cnt[i]++;
          last_w[i] = cap_w[i];
          w_got[i]  = 1'b1;
        end
        if (aw_got[i] && w_got[i] && !sl_bvalid[i]) begin
          sl_bvalid[i] = 1'b1;
          aw_got[i]    = 1'b0;
          w_got[i]     = 1'b0;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  function automatic int tb_decode(input logic [31:0] a, output logic [31:0] off);
    logic [63:0] x;
    x = 64'(a);
    off = 32'h0;
    if (x >= 64'h0200_0000 && x < 64'h0201_0000) begin
      off = a - 32'h0200_0000;
      return 0;
    end
    if (x >= 64'h1000_0000 && x < 64'h1000_1000) begin
      off = a - 32'h1000_0000;
      return 1;
    end
    return 2;
  endfunction

  logic        rd_act = 1'b0, rd_adone = 1'b0;
  int          rd_tgt = 0;
  logic [31:0] rd_off = '0;
  logic        wr_aw = 1'b0, wr_w = 1'b0, wr_adone = 1'b0, wr_wdone = 1'b0;
  int          wr_tgt = 0;
  logic [31:0] wr_off = '0;
  logic [63:0] wr_data = '0;
  int          r_cnt = 0, b_cnt = 0;
  logic [63:0] last_rdata = '0;
  logic [1:0]  last_rresp = '0, last_bresp = '0;

  always @(negedge clk) begin : cmp
    logic e_rv, e_bv, both, f_ar, f_mar, f_r, f_aw, f_w, f_maw, f_mw, f_b;
    if (rst) begin
      rd_act = 1'b0; rd_adone = 1'b0;
      wr_aw = 1'b0; wr_w = 1'b0; wr_adone = 1'b0; wr_wdone = 1'b0;
    end else begin
      // read channel
      chk1("arready", s_axi_arready, !rd_act);
      chk1("m0_arvalid", m0_axi_arvalid, rd_act && rd_tgt == 0 && !rd_adone);
      chk1("m1_arvalid", m1_axi_arvalid, rd_act && rd_tgt == 1 && !rd_adone);
      if (m0_axi_arvalid) chk("m0_araddr", 64'(m0_axi_araddr), 64'(rd_off[15:0]));
      if (m1_axi_arvalid) chk("m1_araddr", 64'(m1_axi_araddr), 64'(rd_off));
      e_rv = rd_act && (rd_tgt == 2 || (rd_adone && sl_rvalid[rd_tgt == 1 ? 1 : 0]));
      chk1("rvalid", s_axi_rvalid, e_rv);
      if (e_rv) begin
        chk("rdata", s_axi_rdata, rd_tgt == 2 ? 64'h0 : sl_rdata[rd_tgt == 1 ? 1 : 0]);
        chk("rresp", 64'(s_axi_rresp), rd_tgt == 2 ? 64'h3 : 64'(rd_tgt));
      end
      chk1("m0_rready", m0_axi_rready, rd_act && rd_tgt == 0 && rd_adone && s_axi_rready);
      chk1("m1_rready", m1_axi_rready, rd_act && rd_tgt == 1 && rd_adone && s_axi_rready);
      // write channel
      both = wr_aw && wr_w;
      chk1("awready", s_axi_awready, !wr_aw);
      chk1("wready", s_axi_wready, !wr_w);
      chk1("m0_awvalid", m0_axi_awvalid, both && wr_tgt == 0 && !wr_adone);
      chk1("m1_awvalid", m1_axi_awvalid, both && wr_tgt == 1 && !wr_adone);
      chk1("m0_wvalid", m0_axi_wvalid, both && wr_tgt == 0 && !wr_wdone);
      chk1("m1_wvalid", m1_axi_wvalid, both && wr_tgt == 1 && !wr_wdone);
      if (m0_axi_awvalid) chk("m0_awaddr", 64'(m0_axi_awaddr), 64'(wr_off[15:0]));
      if (m1_axi_awvalid) chk("m1_awaddr", 64'(m1_axi_awaddr), 64'(wr_off));
      if (m0_axi_wvalid) chk("m0_wdata", m0_axi_wdata, wr_data);
      if (m1_axi_wvalid) chk("m1_wdata", m1_axi_wdata, wr_data);
      e_bv = both && (wr_tgt == 2 ||
                      (wr_adone && wr_wdone && sl_bvalid[wr_tgt == 1 ? 1 : 0]));
      chk1("bvalid", s_axi_bvalid, e_bv);
      if (e_bv) chk("bresp", 64'(s_axi_bresp), wr_tgt == 2 ? 64'h3 : 64'h0);
      chk1("m0_bready", m0_axi_bready, both && wr_tgt == 0 && wr_adone && wr_wdone && s_axi_bready);
      chk1("m1_bready", m1_axi_bready, both && wr_tgt == 1 && wr_adone && wr_wdone && s_axi_bready);
      // handshakes taking effect at the coming edge
      f_ar  = s_axi_arvalid && s_axi_arready;
      f_mar = (m0_axi_arvalid && m0_axi_arready) || (m1_axi_arvalid && m1_axi_arready);
      f_r   = s_axi_rvalid && s_axi_rready;
      f_aw  = s_axi_awvalid && s_axi_awready;
      f_w   = s_axi_wvalid && s_axi_wready;
      f_maw = (m0_axi_awvalid && m0_axi_awready) || (m1_axi_awvalid && m1_axi_awready);
      f_mw  = (m0_axi_wvalid && m0_axi_wready) || (m1_axi_wvalid && m1_axi_wready);
      f_b   = s_axi_bvalid && s_axi_bready;
      if (f_mar) rd_adone = 1'b1;
      if (f_r) begin
        rd_act = 1'b0;
        r_cnt++;
        last_rdata = s_axi_rdata;
        last_rresp = s_axi_rresp;
      end
      if (f_ar) begin
        rd_act   = 1'b1;
        rd_adone = 1'b0;
        rd_tgt   = tb_decode(s_axi_araddr, rd_off);
      end
      if (f_maw) wr_adone = 1'b1;
      if (f_mw) wr_wdone = 1'b1;
      if (f_b) begin
        wr_aw = 1'b0; wr_w = 1'b0; wr_adone = 1'b0; wr_wdone = 1'b0;
        b_cnt++;
        last_bresp = s_axi_bresp;
      end
      if (f_aw) begin
        wr_aw  = 1'b1;
        wr_tgt = tb_decode(s_axi_awaddr, wr_off);
      end
      if (f_w) begin
        wr_w    = 1'b1;
        wr_data = s_axi_wdata;
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_arready) timeout("ar");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_awready) timeout("aw");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d);
    int n = 0;
    s_axi_wdata  = d;
    s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_wready) timeout("w");
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_r();
    int n = 0;
    @(negedge clk);
    while (!(s_axi_rvalid && s_axi_rready) && n < 50) begin @(negedge clk); n++; end
    if (!(s_axi_rvalid && s_axi_rready)) timeout("r");
    @(posedge clk); #1;
  endtask

  task automatic wait_b();
    int n = 0;
    @(negedge clk);
    while (!(s_axi_bvalid && s_axi_bready) && n < 50) begin @(negedge clk); n++; end
    if (!(s_axi_bvalid && s_axi_bready)) timeout("b");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want end @%0t", $time);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  logic [31:0] edge_addr [8];
  logic [1:0]  edge_resp [8];
  int          c0, c1, c2, c3;

  initial begin
    edge_addr = '{32'h01FF_FFFF, 32'h0200_0000, 32'h0200_FFFF, 32'h0201_0000,
                  32'h0FFF_FFFF, 32'h1000_0FFF, 32'h1000_1000, 32'hFFFF_FFFF};
    edge_resp = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    for (int i = 0; i < 2; i++) begin
      sl_arready[i] = 1'b1; sl_rvalid[i] = 1'b0; sl_rdata[i] = '0; sl_bvalid[i] = 1'b0;
      rd_ret[i] = '0; aw_got[i] = 1'b0; w_got[i] = 1'b0;
      ar_cnt[i] = 0; aw_cnt[i] = 0; w_cnt[i] = 0;
      last_ar[i] = '0; last_aw[i] = '0; last_w[i] = '0;
    end
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk1("rst_arready", s_axi_arready, 1'b1);
    chk1("rst_awready", s_axi_awready, 1'b1);
    chk1("rst_wready", s_axi_wready, 1'b1);
    chk1("rst_rvalid", s_axi_rvalid, 1'b0);
    chk1("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rdata", s_axi_rdata, 64'h0);
    chk("rst_resps", 64'({s_axi_bresp, s_axi_rresp}), 64'h0);
    chk("rst_mvalids", 64'({m0_axi_arvalid, m1_axi_arvalid, m0_axi_awvalid, m1_axi_awvalid,
                            m0_axi_wvalid, m1_axi_wvalid}), 64'h0);

    // CLINT mtime read
    rd_ret[0] = 64'h1234;
    send_ar(32'h0200_BFF8);
    wait_r();
    chk("mtime_araddr", 64'(last_ar[0]), 64'hBFF8);
    chk("mtime_m1_idle", 64'(ar_cnt[1]), 64'h0);
    chk("mtime_rdata", last_rdata, 64'h1234);
    chk("mtime_rresp", 64'(last_rresp), 64'h0);

    // mtimecmp write, W one cycle ahead of AW
    c0 = b_cnt;
    fork
      send_w(64'd500);
      begin @(posedge clk); #1; send_aw(32'h0200_4000); end
    join
    wait_b();
    repeat (4) @(posedge clk);
    #1;
    chk("mtimecmp_awaddr", 64'(last_aw[0]), 64'h4000);
    chk("mtimecmp_wdata", last_w[0], 64'd500);
    chk("mtimecmp_bcount", 64'(b_cnt - c0), 64'h1);
    chk("mtimecmp_bresp", 64'(last_bresp), 64'h0);

    // unmapped read and write
    c0 = ar_cnt[0] + ar_cnt[1];
    send_ar(32'h3000_0000);
    wait_r();
    chk("unmap_rresp", 64'(last_rresp), 64'h3);
    chk("unmap_rdata", last_rdata, 64'h0);
    chk("unmap_no_ar", 64'(ar_cnt[0] + ar_cnt[1]), 64'(c0));
    c1 = aw_cnt[0] + aw_cnt[1] + w_cnt[0] + w_cnt[1];
    fork
      send_aw(32'h3000_0000);
      send_w(64'hFFFF);
    join
    wait_b();
    chk("unmap_bresp", 64'(last_bresp), 64'h3);
    chk("unmap_no_w", 64'(aw_cnt[0] + aw_cnt[1] + w_cnt[0] + w_cnt[1]), 64'(c1));

    // read response backpressure with a second AR already waiting
    s_axi_rready = 1'b0;
    rd_ret[1] = 64'hDEAD_BEEF_0000_0001;
    rd_ret[0] = 64'h0000_0000_0000_0ABC;
    send_ar(32'h1000_0040);
    s_axi_araddr  = 32'h0200_0008;
    s_axi_arvalid = 1'b1;
    c0 = 0;
    @(negedge clk);
    while (!s_axi_rvalid && c0 < 50) begin @(negedge clk); c0++; end
    if (!s_axi_rvalid) timeout("bp_rvalid");
    for (int k = 0; k < 5; k++) begin
      chk("bp_rdata", s_axi_rdata, 64'hDEAD_BEEF_0000_0001);
      chk1("bp_arready", s_axi_arready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b1;
    @(negedge clk);
    chk1("bp_handshake", s_axi_rvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("bp_reaccept", s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    wait_r();
    chk("bp_second_addr", 64'(last_ar[0]), 64'h0008);
    chk("bp_second_data", last_rdata, 64'h0ABC);

    // simultaneous read (device) and write (CLINT)
    rd_ret[1] = 64'h5555_AAAA_0000_0010;
    c0 = r_cnt; c1 = b_cnt; c2 = ar_cnt[1]; c3 = aw_cnt[0];
    fork
      send_ar(32'h1000_0010);
      send_aw(32'h0200_0000);
      send_w(64'd1);
    join
    fork
      wait_r();
      wait_b();
    join
    chk("conc_m1_araddr", 64'(last_ar[1]), 64'h10);
    chk("conc_m0_awaddr", 64'(last_aw[0]), 64'h0);
    chk("conc_m0_wdata", last_w[0], 64'h1);
    chk("conc_issued", 64'({ar_cnt[1] - c2, aw_cnt[0] - c3}), {32'h1, 32'h1});
    chk("conc_resps", 64'({r_cnt - c0, b_cnt - c1}), {32'h1, 32'h1});
    chk("conc_rdata", last_rdata, 64'h5555_AAAA_0000_0010);

    // window edges, including the all-ones address
    for (int i = 0; i < 8; i++) begin
      send_ar(edge_addr[i]);
      wait_r();
      chk($sformatf("edge_rresp_%0d", i), 64'(last_rresp), 64'(edge_resp[i]));
    end
    fork
      send_aw(32'h1000_0FF8);
      send_w(64'hCAFE);
    join
    wait_b();
    chk("dev_awaddr", 64'(last_aw[1]), 64'h0FF8);
    chk("dev_wdata", last_w[1], 64'hCAFE);

    // reset while the read sits in the address phase
    sl_arready[0] = 1'b0;
    c0 = r_cnt; c1 = ar_cnt[0];
    send_ar(32'h0200_0100);
    @(negedge clk);
    chk1("midrst_pending", m0_axi_arvalid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sl_arready[0] = 1'b1;
    chk1("midrst_m0_arvalid", m0_axi_arvalid, 1'b0);
    chk1("midrst_arready", s_axi_arready, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_rresp", 64'(r_cnt - c0), 64'h0);
    chk("midrst_no_ar", 64'(ar_cnt[0] - c1), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_axi_demux.md
Name: mmio_axi_demux

Overview:
- 1-to-2 AXI-lite style address-decoding demultiplexer between the core's MMIO master port and the SoC peripheral slaves.
- Target 0 is the CLINT and takes 16-bit offsets; target 1 is the generic device window.
- Unmapped addresses complete locally with DECERR.
- One outstanding read and one outstanding write. The read and write paths are independent.

Parameters:
- CLINT_BASE, 32'h0200_0000, base of target 0 window.
- CLINT_SIZE, 32'h0001_0000, size of target 0 window (power of two).
- DEV_BASE, 32'h1000_0000, base of target 1 window.
- DEV_SIZE, 32'h0000_1000, size of target 1 window (power of two).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_{awaddr,araddr}  in  32  upstream addresses
- s_axi_wdata  in  64  upstream write data
- s_axi_{awvalid,wvalid,bready,arvalid,rready}  in  1  upstream handshakes
- s_axi_{awready,wready,bvalid,arready,rvalid}  out  1  upstream handshakes
- s_axi_{bresp,rresp}  out  2  upstream responses
- s_axi_rdata  out  64  upstream read data
- m0_axi_{awaddr,araddr}  out  16  CLINT offsets
- m1_axi_{awaddr,araddr}  out  32  device offsets (addr - DEV_BASE)
- mN_axi_wdata  out  64, mN_axi_rdata  in  64  (N = 0, 1)
- mN_axi_{awvalid,wvalid,bready,arvalid,rready}  out  1
- mN_axi_{awready,wready,bvalid,arready,rvalid}  in  1
- mN_axi_{bresp,rresp}  in  2

Behaviour:
- Decode: target 0 if CLINT_BASE <= a < CLINT_BASE+CLINT_SIZE; else target 1 if in DEV window; else ERR. Offset = a - base, truncated to the master address width.
- Reset values:
  - s_arready = 1, s_awready = 1, s_wready = 1.
  - s_rvalid = 0, s_bvalid = 0.
  - All m*_valid = 0, all m*_ready = 0.
  - rdata = 0; bresp = rresp = 0.
  - FSMs in IDLE.
- Read FSM R_IDLE -> R_ADDR -> R_RESP -> R_IDLE, or R_IDLE -> R_ERR -> R_IDLE:
  - R_IDLE, arvalid & arready: latch offset and target, drop arready next cycle. Go to R_ADDR with mT_arvalid = 1 (registered), or to R_ERR.
  - R_ADDR: hold mT_arvalid and address stable until mT_arready. Next cycle go to R_RESP with mT_arvalid = 0.
  - R_RESP: combinational pass-through.
    - s_rvalid = mT_rvalid; mT_rready = s_rready; s_rdata/s_rresp from target T.
    - On handshake go to R_IDLE with arready = 1 next cycle.
  - R_ERR: s_rvalid = 1, rdata = 0, rresp = 2'b11 (DECERR), held until s_rready. Then go to R_IDLE.
  - Minimum latency: AR accept to R_ADDR is 1 cycle; the target response is passed through with 0 added cycles.
- Write FSM W_IDLE -> W_FWD -> W_RESP -> W_IDLE, or W_IDLE -> W_ERR -> W_IDLE:
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. Each ready drops the cycle after its own handshake.
  - W_IDLE, both captured: go to W_FWD asserting mT_awvalid and mT_wvalid. If the target is ERR, go to W_ERR instead.
  - W_FWD: each valid deasserts after its own handshake. When both are done, go to W_RESP.
  - W_RESP: pass through B (s_bvalid = mT_bvalid, mT_bready = s_bready, bresp from target). On handshake, set awready = wready = 1 and return to W_IDLE.
  - W_ERR: s_bvalid = 1, bresp = 2'b11, held until bready. The target sees no traffic.
- Unselected targets: all valids/readys to the non-addressed target are 0 at all times.
- Simultaneous read and write: legal, including to the same target; the two FSMs never interact.
- Response backpressure: the held response stays stable and no new address is accepted until it completes.
- Reset mid-transaction: all state is abandoned and no response is issued. Downstream slaves share rst.
- Address 0xFFFF_FFFF and window top edges: the comparison is exclusive at base+size. Computing base+size in 33 bits means no wrap.

Decomposition:
- Shared package axi_pkg:
  - constants AXI_RESP_OKAY = 2'b00, AXI_RESP_DECERR = 2'b11;
  - enums rd_state_t {R_IDLE, R_ADDR, R_RESP, R_ERR} and wr_state_t {W_IDLE, W_FWD, W_RESP, W_ERR};
  - typedef tgt_t {TGT_CLINT, TGT_DEV, TGT_ERR}.
- One combinational sub-module, mmio_addr_decode (addr -> tgt_t + offset), instantiated once for AR and once for AW.

Test Plan:
- Read of CLINT mtime: read 32'h0200_BFF8 -> m0_araddr = 16'hBFF8, m1 idle. Target returns 64'h1234 -> s_rdata = 64'h1234, rresp = 0.
- Write to CLINT mtimecmp: AW 32'h0200_4000 with W 64'd500 sent one cycle before AW -> m0_awaddr = 16'h4000, m0_wdata = 500, exactly one B with bresp = 0.
- Unmapped read: read 32'h3000_0000 -> no m0/m1 valid, s_rresp = 2'b11, s_rdata = 0. Unmapped write: write 32'h3000_0000 -> s_bresp = 2'b11.
- Backpressure: target rvalid with s_rready low for 5 cycles -> rdata stable, arready stays 0. A new AR is accepted the cycle after the handshake.
- Concurrency: read 32'h1000_0010 and write 32'h0200_0000 (data 1) in the same cycle -> m1_araddr = 32'h10 and m0_awaddr = 0 both issued, both responses returned.
- Reset mid-op: rst asserted in R_ADDR -> next cycle all m* valid = 0, s_arready = 1, and no s_rvalid ever issued.
